// File: rtl/fifo_defs.sv
// Shared FIFO geometry: default widths, derived depth and count width,
// and the per-cycle operation encoding used by the FIFO controller.
package fifo_defs;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // Number of entries addressed by an ADDR_WIDTH-bit pointer.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEFAULT_DEPTH       = fifo_depth(DEFAULT_ADDR_WIDTH);
  localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_ADDR_WIDTH);

  // Accepted operation in a cycle, encoded as {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
// The array itself is never reset; only the read-data register is.
module ram_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: store wr_data at wr_addr when enabled.
  // NOTE: the storage array has no reset so it maps onto RAM macros/LUTRAM; stale contents are unreachable because the pointers are reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read port: register the addressed word on a read; hold otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rd_data <= '0;
    end else if (re) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, read-valid strobe,
// push-through at full, occupancy flags with programmable thresholds, and
// sticky overflow/underflow error flags.
module fifo_param
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic [ADDR_WIDTH:0]   umb_almost_full,
  input  logic [ADDR_WIDTH:0]   umb_almost_empty,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_data_valid;
  logic                  r_overflow_err;
  logic                  r_underflow_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  fifo_op_e              w_op;

  // Occupancy flags are decoded straight from the count register.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Accept logic: a push at full is allowed only alongside a pop; no bypass at empty.
  // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    w_push = write & (~w_full | read);
    w_pop  = read & ~w_empty;
    w_op   = fifo_op_e'({w_push, w_pop});
  end

  ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset_L (reset_L),
    .we      (w_push),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .re      (w_pop),
    .rd_addr (r_rd_ptr),
    .rd_data (data_out)
  );

  // Pointer advance on accepted push/pop; natural wrap at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
    end
  end

  // Occupancy counter: accept logic guarantees it stays within 0..DEPTH.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_count <= r_count + CW'(1);
        OP_POP:  r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid strobe: high for exactly the cycle after an accepted pop.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_pop;
    end
  end

  // Sticky error flags: a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_overflow_err  <= (write & ~w_push) | (r_overflow_err  & ~err_clr);
      r_underflow_err <= (read  & ~w_pop)  | (r_underflow_err & ~err_clr);
    end
  end

  assign data_valid    = r_data_valid;
  assign data_count    = r_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (r_count >= umb_almost_full);
  assign almost_empty  = (r_count <= umb_almost_empty) & ~w_empty;
  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fifo_param;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          write;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW:0]   umb_af;
  logic [AW:0]   umb_ae;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [AW:0]   data_count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_valid, m_ovf, m_unf;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .write            (write),
    .data_in          (data_in),
    .read             (read),
    .umb_almost_full  (umb_af),
    .umb_almost_empty (umb_ae),
    .err_clr          (err_clr),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .data_count       (data_count),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock: drive inputs, apply the edge, advance the model, settle.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d, input logic clr);
    bit push_ok, pop_ok;
    write = wr; read = rd; data_in = d; err_clr = clr;
    @(posedge clk);
    push_ok = wr && (mq.size() < DEPTH || rd);
    pop_ok  = rd && (mq.size() > 0);
    m_valid = pop_ok;
    if (pop_ok)  m_dout = mq.pop_front();
    if (push_ok) mq.push_back(d);
    m_ovf = (wr && !push_ok) || (m_ovf && !clr);
    m_unf = (rd && !pop_ok)  || (m_unf && !clr);
    #1;
    write = 1'b0; read = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; write = 1'b0; read = 1'b0; data_in = '0; err_clr = 1'b0;
    umb_af = 3'd3; umb_ae = 3'd1;
    model_reset();
    #2;
    tot_cnt++; if (data_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", data_count); else pass_cnt++;
    tot_cnt++; if ({empty, full, almost_full, almost_empty} !== 4'b1000)
      $display("FAIL reset_flags got %b exp 1000", {empty, full, almost_full, almost_empty}); else pass_cnt++;
    tot_cnt++; if ({data_valid, overflow_err, underflow_err} !== 3'b000 || data_out !== 8'h00)
      $display("FAIL reset_outputs got v/o/u=%b dout=%h exp 000 00", {data_valid, overflow_err, underflow_err}, data_out); else pass_cnt++;
    #10 reset_L = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'hA1 + 8'(i), 1'b0);
      tot_cnt++; if (data_count !== 3'(i + 1)) $display("FAIL fill_count got %0d exp %0d", data_count, i + 1); else pass_cnt++;
      tot_cnt++; if ({almost_full, full} !== {(i >= 2), (i == 3)})
        $display("FAIL fill_flags af/full got %b exp %b", {almost_full, full}, {(i >= 2), (i == 3)}); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      tot_cnt++; if (data_out !== 8'hA1 + 8'(i) || data_valid !== 1'b1)
        $display("FAIL drain_data got %h v=%b exp %h v=1", data_out, data_valid, 8'hA1 + 8'(i)); else pass_cnt++;
    end
    tot_cnt++; if ({empty, overflow_err, underflow_err, data_count} !== {3'b100, 3'd0})
      $display("FAIL drain_end got e/o/u=%b cnt=%0d exp 100 0", {empty, overflow_err, underflow_err}, data_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hE0 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    tot_cnt++; if (data_count !== 3'd4 || overflow_err !== 1'b1)
      $display("FAIL ovf_set got cnt=%0d ovf=%b exp 4 1", data_count, overflow_err); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tot_cnt++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow_err); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    tot_cnt++; if (overflow_err !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow_err); else pass_cnt++;
    // A new overflow in the clearing cycle keeps the flag set.
    step(1'b1, 1'b0, 8'hFE, 1'b1);
    tot_cnt++; if (overflow_err !== 1'b1) $display("FAIL ovf_clr_collide got %b exp 1", overflow_err); else pass_cnt++;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      tot_cnt++; if (data_out !== 8'hE0 + 8'(i)) $display("FAIL ovf_contents got %h exp %h", data_out, 8'hE0 + 8'(i)); else pass_cnt++;
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hB1 + 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hB5, 1'b0);
    tot_cnt++; if (data_count !== 3'd4 || data_out !== 8'hB1 || data_valid !== 1'b1)
      $display("FAIL simfull got cnt=%0d dout=%h v=%b exp 4 b1 1", data_count, data_out, data_valid); else pass_cnt++;
    tot_cnt++; if ({overflow_err, underflow_err} !== 2'b00)
      $display("FAIL simfull_err got %b exp 00", {overflow_err, underflow_err}); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      tot_cnt++; if (data_out !== 8'hB2 + 8'(i)) $display("FAIL simfull_drain got %h exp %h", data_out, 8'hB2 + 8'(i)); else pass_cnt++;
    end
  endtask

  task automatic test_simul_empty();
    step(1'b1, 1'b1, 8'hC1, 1'b0);
    tot_cnt++; if (data_count !== 3'd1 || underflow_err !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL simempty got cnt=%0d unf=%b v=%b exp 1 1 0", data_count, underflow_err, data_valid); else pass_cnt++;
    tot_cnt++; if ({almost_empty, empty} !== 2'b10)
      $display("FAIL simempty_flags ae/e got %b exp 10", {almost_empty, empty}); else pass_cnt++;
    step(1'b0, 1'b1, 8'h00, 1'b1);
    tot_cnt++; if (data_out !== 8'hC1 || data_valid !== 1'b1 || underflow_err !== 1'b0)
      $display("FAIL simempty_pop got %h v=%b unf=%b exp c1 1 0", data_out, data_valid, underflow_err); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] lq[$];
    logic [DW-1:0] d, exp_d;
    int max_cnt = 0;
    d = 8'h50;
    step(1'b1, 1'b0, d, 1'b0); lq.push_back(d);
    for (int i = 0; i < 10; i++) begin
      d = 8'h60 + 8'(i);
      step(1'b1, 1'b0, d, 1'b0); lq.push_back(d);
      if (int'(data_count) > max_cnt) max_cnt = int'(data_count);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      exp_d = lq.pop_front();
      tot_cnt++; if (data_out !== exp_d || data_valid !== 1'b1)
        $display("FAIL wrap_data got %h v=%b exp %h v=1", data_out, data_valid, exp_d); else pass_cnt++;
    end
    tot_cnt++; if (max_cnt != 2) $display("FAIL wrap_maxcount got %0d exp 2", max_cnt); else pass_cnt++;
    step(1'b0, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);   // leave valid high; count now 2
    step(1'b1, 1'b1, 8'h11, 1'b0);   // valid high again, count stays 2
    step(1'b1, 1'b0, 8'h12, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h13, 1'b0);   // pop + push: count 3, valid 1
    step(1'b1, 1'b0, 8'h14, 1'b0);   // count 4 -> pop one to make 3 with valid high
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);   // overflow-free push/pop, leaves count 3
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 2
    step(1'b1, 1'b0, 8'h15, 1'b0);   // count 3
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 2, valid 1
    step(1'b1, 1'b1, 8'h16, 1'b0);   // count 2
    step(1'b1, 1'b1, 8'h17, 1'b1);   // count 2, valid 1
    step(1'b1, 1'b0, 8'h18, 1'b0);   // count 3
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 2, valid 1
    step(1'b1, 1'b1, 8'h19, 1'b0);   // count 2, valid 1
    step(1'b1, 1'b0, 8'h1A, 1'b0);   // count 3
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 2
    step(1'b1, 1'b1, 8'h1B, 1'b0);
    step(1'b1, 1'b0, 8'h1C, 1'b0);   // count 3
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 2, valid high
    step(1'b1, 1'b1, 8'h1D, 1'b0);   // count 2, valid high
    step(1'b1, 1'b1, 8'h1E, 1'b0);   // count 2, valid high
    step(1'b0, 1'b1, 8'h00, 1'b0);   // count 1, valid high
    step(1'b1, 1'b1, 8'h1F, 1'b0);   // count 1
    step(1'b1, 1'b1, 8'h20, 1'b0);
    step(1'b1, 1'b0, 8'h21, 1'b0);   // count 2
    step(1'b1, 1'b1, 8'h22, 1'b0);   // count 2, valid high
    step(1'b1, 1'b0, 8'h23, 1'b0);   // count 3
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h24, 1'b0);   // count 3, valid high
    tot_cnt++; if (data_count !== 3'd3 || data_valid !== 1'b1)
      $display("FAIL rstmid_pre got cnt=%0d v=%b exp 3 1", data_count, data_valid); else pass_cnt++;
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    tot_cnt++; if (data_count !== 3'd0 || empty !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL rstmid_async got cnt=%0d e=%b v=%b exp 0 1 0", data_count, empty, data_valid); else pass_cnt++;
    tot_cnt++; if ({overflow_err, underflow_err} !== 2'b00)
      $display("FAIL rstmid_err got %b exp 00", {overflow_err, underflow_err}); else pass_cnt++;
    @(negedge clk) reset_L = 1'b1;
    #1;
    step(1'b1, 1'b0, 8'hD0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    tot_cnt++; if (data_out !== 8'hD0 || data_valid !== 1'b1 || data_count !== 3'd0)
      $display("FAIL rstmid_after got %h v=%b cnt=%0d exp d0 1 0", data_out, data_valid, data_count); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    int n;
    umb_af = 3'($urandom_range(0, 4));
    umb_ae = 3'($urandom_range(0, 4));
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 100) < 55, ($urandom % 100) < 50, 8'($urandom), ($urandom % 16) == 0);
      n = mq.size();
      exp = {3'(n), (n == DEPTH), (n == 0), (n >= int'(umb_af)), (n <= int'(umb_ae) && n != 0),
             m_ovf, m_unf, m_valid};
      got = {data_count, full, empty, almost_full, almost_empty, overflow_err, underflow_err, data_valid};
      tot_cnt++; if (got !== exp) $display("FAIL rand_status cyc %0d got %b exp %b", i, got, exp); else pass_cnt++;
      tot_cnt++; if (data_out !== m_dout) $display("FAIL rand_data cyc %0d got %h exp %h", i, data_out, m_dout); else pass_cnt++;
      if (i == 200) begin
        umb_af = 3'($urandom_range(0, 4));
        umb_ae = 3'($urandom_range(0, 4));
      end
    end
    umb_af = 3'd3; umb_ae = 3'd1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, successor to the fixed-geometry FIFO in the flow-control path. Data width and depth are independent parameters. All 2**ADDR_WIDTH entries are usable. The block adds a registered read-data valid strobe, a simultaneous push/pop at full, and sticky overflow/underflow error flags with a clear input. It sits between a producer port and a consumer port and feeds the almost-full/almost-empty back-pressure logic.

## Interface
- DATA_WIDTH, 8, bits per entry
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries
- clk  in  1  single clock, all logic on rising edge
- reset_L  in  1  asynchronous, active-low reset
- write  in  1  push request
- data_in  in  DATA_WIDTH  push data
- read  in  1  pop request
- umb_almost_full  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
- umb_almost_empty  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
- err_clr  in  1  clears sticky error flags
- data_out  out  DATA_WIDTH  popped data, registered
- data_valid  out  1  one-cycle strobe, data_out holds a new pop
- data_count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1  occupancy flags
- overflow_err, underflow_err  out  1  sticky error flags

## Operation
- push_ok = write & (~full | read). pop_ok = read & ~empty.
- A push at full with a concurrent pop succeeds. No bypass exists: a read at empty is rejected even with a concurrent write.
- push_ok: mem[wr_ptr] <= data_in, wr_ptr += 1 (mod DEPTH).
- pop_ok: data_out <= mem[rd_ptr], rd_ptr += 1 (mod DEPTH), data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
- data_count: +1 on push only, -1 on pop only, unchanged on both or neither. Width ADDR_WIDTH+1 so DEPTH is representable. It never wraps.
- Flags are decoded combinationally from the data_count register:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (count >= umb_almost_full)
  - almost_empty = (count <= umb_almost_empty) & (count != 0)
- overflow_err is set when write & ~push_ok. underflow_err is set when read & ~pop_ok. Both are sticky.
- err_clr clears both error flags on the next edge. A new error in the same cycle as err_clr wins, so the flag stays 1.
- Reset (reset_L=0, asynchronous assert) forces:
  - pointers = 0, data_count = 0, data_out = 0, data_valid = 0
  - both error flags = 0
  - resulting flags: empty = 1, full = 0, almost_full = (umb_almost_full==0), almost_empty = 0
- Memory contents are not cleared by reset.
- Reset mid-operation discards all stored entries. Release is synchronous to the next rising edge.

## Timing
- Write-to-read latency: an entry pushed at edge N can be popped at edge N+1. Its data_out and data_valid are visible after edge N+1.
- Read latency: 1 cycle. Pop accepted at edge N gives data_out and data_valid stable from edge N until edge N+1.
- Flags and data_count update at the same edge as the push/pop that changes them.
- The error flag asserts at the edge of the offending request.

## Structure
- A shared package/include fifo_defs holds:
  - default DATA_WIDTH and ADDR_WIDTH
  - the derived constant DEPTH and the count-width rule (ADDR_WIDTH+1), shared with the back-pressure logic
- One sub-module, ram_dp:
  - DATA_WIDTH x DEPTH array
  - synchronous write port (we, wr_addr, wr_data)
  - synchronous read port (re, rd_addr, rd_data registered)
  - no reset on the array
- data_out comes directly from the ram_dp registered read port.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), umb_almost_full=3, umb_almost_empty=1.
- Fill then drain:
  - push 0xA1..0xA4 -> count 1,2,3,4; almost_full at count 3; full at 4.
  - pop 4 -> data_out 0xA1..0xA4 with data_valid each cycle; empty at end; no errors.
- Overflow: push a 5th word at full with no read -> count stays 4, overflow_err=1 and sticky. Pulse err_clr -> overflow_err=0 next cycle.
- Simultaneous at full: count=4, write=read=1 with 0xB5 -> count stays 4, data_out = oldest entry, 0xB5 stored, no error.
- Simultaneous at empty: write=read=1 with 0xC1 -> 0xC1 stored, count=1, underflow_err=1, data_valid=0.
- Wrap-around: 10 interleaved push/pop pairs through 4 entries -> data order preserved across pointer wrap; count never exceeds 2.
- Reset mid-operation: count=3, drop reset_L between edges -> immediately count=0, empty=1, data_valid=0, errors=0. After release, push 0xD0 and pop -> 0xD0 returned.
